// File: rtl/board_renderer_if.sv
// Game-logic side port of the board renderer: cell writes with valid/ready
// handshake plus the line-clear start request and sequencer status.
interface board_renderer_if #(
  parameter int GRID_LOG2 = 3,
  parameter int COLOR_W   = 3
);
  localparam int GRID_N = 1 << GRID_LOG2;

  logic                 wr_valid;
  logic                 wr_ready;
  logic [GRID_LOG2-1:0] wr_x;
  logic [GRID_LOG2-1:0] wr_y;
  logic [COLOR_W-1:0]   wr_color;
  logic                 flash_start;
  logic [GRID_N-1:0]    flash_rows;
  logic [GRID_N-1:0]    flash_cols;
  logic                 busy;

  modport master (
    output wr_valid, wr_x, wr_y, wr_color, flash_start, flash_rows, flash_cols,
    input  wr_ready, busy
  );

  modport slave (
    input  wr_valid, wr_x, wr_y, wr_color, flash_start, flash_rows, flash_cols,
    output wr_ready, busy
  );
endinterface

// File: rtl/board_renderer.sv
// Live GRID_N x GRID_N board renderer: grid lines, dark surround, cell-colour
// store written by game logic, and a blink-then-erase line-clear sequencer.
module board_renderer #(
  parameter logic [11:0] ORG_X        = 12'd512,
  parameter logic [10:0] ORG_Y        = 11'd256,
  parameter int          CELL_LOG2    = 6,
  parameter int          GRID_LOG2    = 3,
  parameter int          COLOR_W      = 3,
  parameter int          FLASH_FRAMES = 32
) (
  input  logic            iCLK,
  input  logic            reset,
  input  logic [11:0]     HCNT,
  input  logic [10:0]     VCNT,
  input  logic            frame_start,
  board_renderer_if.slave bus,
  output logic [7:0]      R,
  output logic [7:0]      G,
  output logic [7:0]      B
);
  localparam int          GRID_N     = 1 << GRID_LOG2;
  localparam int          CELLS      = GRID_N * GRID_N;
  localparam logic [12:0] BOARD_W    = 13'(GRID_N << CELL_LOG2);
  localparam logic [11:0] BOARD_H    = 12'(GRID_N << CELL_LOG2);
  localparam logic [7:0]  FLASH_LAST = 8'(FLASH_FRAMES - 1);

  localparam logic [23:0] C_OUT   = {8'd38, 8'd38, 8'd38};
  localparam logic [23:0] C_LINE  = {8'd89, 8'd89, 8'd89};
  localparam logic [23:0] C_WHITE = {8'd255, 8'd255, 8'd255};

  typedef enum logic [1:0] {IDLE = 2'd0, FLASH = 2'd1, CLEAR = 2'd2} state_t;

  state_t               state_r;
  logic [7:0]           frame_cnt_r;
  logic [GRID_N-1:0]    rows_r;
  logic [GRID_N-1:0]    cols_r;
  logic [COLOR_W-1:0]   cell_r [CELLS];

  logic [11:0]          dx_s;
  logic [10:0]          dy_s;
  logic                 inside_s;
  logic                 line_s;
  logic                 s1_inside_r;
  logic                 s1_line_r;
  logic [GRID_LOG2-1:0] s1_row_r;
  logic [GRID_LOG2-1:0] s1_col_r;
  logic [COLOR_W-1:0]   s2_color_s;
  logic                 s2_white_s;
  logic [23:0]          rgb_s;
  logic                 wr_fire_s;
  logic                 start_s;

  function automatic logic [23:0] palette(input logic [COLOR_W-1:0] idx);
    logic [31:0] v;
    v = 32'(idx);
    case (v)
      32'd0:   palette = {8'd64,  8'd64,  8'd64};
      32'd1:   palette = {8'd230, 8'd60,  8'd60};
      32'd2:   palette = {8'd240, 8'd150, 8'd40};
      32'd3:   palette = {8'd240, 8'd220, 8'd60};
      32'd4:   palette = {8'd80,  8'd200, 8'd90};
      32'd5:   palette = {8'd60,  8'd200, 8'd220};
      32'd6:   palette = {8'd60,  8'd100, 8'd230};
      default: palette = {8'd170, 8'd80,  8'd220};
    endcase
  endfunction

  assign bus.wr_ready = (state_r == IDLE);
  assign bus.busy     = (state_r != IDLE);
  assign wr_fire_s    = bus.wr_valid && (state_r == IDLE);
  assign start_s      = (state_r == IDLE) && bus.flash_start &&
                        ((bus.flash_rows | bus.flash_cols) != {GRID_N{1'b0}});

  // Line-clear sequencer: latch masks, count blink frames, then erase for one cycle.
  always_ff @(posedge iCLK) begin
    if (reset) begin
      state_r     <= IDLE;
      frame_cnt_r <= 8'd0;
      rows_r      <= {GRID_N{1'b0}};
      cols_r      <= {GRID_N{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start_s) begin
            state_r     <= FLASH;
            frame_cnt_r <= 8'd0;
            rows_r      <= bus.flash_rows;
            cols_r      <= bus.flash_cols;
          end
        end
        FLASH: begin
          if (frame_start) begin
            if (frame_cnt_r == FLASH_LAST) state_r <= CLEAR;
            else                           frame_cnt_r <= frame_cnt_r + 8'd1;
          end
        end
        CLEAR:   state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  // Cell store: game writes only in IDLE, erase of marked cells only in CLEAR.
  always_ff @(posedge iCLK) begin
    if (reset) begin
      for (int i = 0; i < CELLS; i++) cell_r[i] <= {COLOR_W{1'b0}};
    end else if (wr_fire_s) begin
      cell_r[{bus.wr_y, bus.wr_x}] <= bus.wr_color;
    end else if (state_r == CLEAR) begin
      for (int r = 0; r < GRID_N; r++)
        for (int c = 0; c < GRID_N; c++)
          if (rows_r[GRID_LOG2'(r)] || cols_r[GRID_LOG2'(c)])
            cell_r[{GRID_LOG2'(r), GRID_LOG2'(c)}] <= {COLOR_W{1'b0}};
    end
  end

  assign dx_s     = HCNT - ORG_X;
  assign dy_s     = VCNT - ORG_Y;
  assign inside_s = (HCNT >= ORG_X) && ({1'b0, dx_s} < BOARD_W) &&
                    (VCNT >= ORG_Y) && ({1'b0, dy_s} < BOARD_H);
  assign line_s   = (dx_s[CELL_LOG2-1:0] == {CELL_LOG2{1'b0}}) ||
                    (dy_s[CELL_LOG2-1:0] == {CELL_LOG2{1'b0}});

  // Stage 1: pixel classification and cell coordinates.
  always_ff @(posedge iCLK) begin
    if (reset) begin
      s1_inside_r <= 1'b0;
      s1_line_r   <= 1'b0;
      s1_row_r    <= {GRID_LOG2{1'b0}};
      s1_col_r    <= {GRID_LOG2{1'b0}};
    end else begin
      s1_inside_r <= inside_s;
      s1_line_r   <= line_s;
      s1_row_r    <= dy_s[CELL_LOG2+GRID_LOG2-1:CELL_LOG2];
      s1_col_r    <= dx_s[CELL_LOG2+GRID_LOG2-1:CELL_LOG2];
    end
  end

  // Stage 2 reads the live store, so a write shows up one cycle after its edge.
  assign s2_color_s = cell_r[{s1_row_r, s1_col_r}];
  assign s2_white_s = (state_r == FLASH) && frame_cnt_r[3] &&
                      (rows_r[s1_row_r] || cols_r[s1_col_r]);

  always_comb begin
    rgb_s = C_OUT;
    if (!s1_inside_r)    rgb_s = C_OUT;
    else if (s1_line_r)  rgb_s = C_LINE;
    else if (s2_white_s) rgb_s = C_WHITE;
    else                 rgb_s = palette(s2_color_s);
  end

  always_ff @(posedge iCLK) begin
    if (reset) {R, G, B} <= 24'd0;
    else       {R, G, B} <= rgb_s;
  end
endmodule

// File: tb/tb_board_renderer.sv
// Scoreboard bench for board_renderer: expected pixels are queued at stimulus
// time and popped by a monitor when the tagged pixel emerges two cycles later.
module tb_board_renderer;
  localparam logic [23:0] C_OUT   = 24'h262626;
  localparam logic [23:0] C_LINE  = 24'h595959;
  localparam logic [23:0] C_WHITE = 24'hFFFFFF;
  localparam logic [23:0] C_EMPTY = 24'h404040;
  localparam logic [23:0] C_RED   = 24'hE63C3C;
  localparam logic [23:0] C_YEL   = 24'hF0DC3C;
  localparam logic [23:0] C_GREEN = 24'h50C85A;
  localparam logic [23:0] C_CYAN  = 24'h3CC8DC;

  typedef struct {
    logic [23:0] rgb;
    int          h;
    int          v;
  } exp_t;

  logic        iCLK = 1'b0;
  logic        reset;
  logic [11:0] HCNT;
  logic [10:0] VCNT;
  logic        frame_start;
  logic [7:0]  R, G, B;
  logic        probe, p1, p2;
  int          total = 0;
  int          bad = 0;
  exp_t        exp_q[$];

  board_renderer_if #(.GRID_LOG2(3), .COLOR_W(3)) bus();

  board_renderer dut (
    .iCLK(iCLK), .reset(reset), .HCNT(HCNT), .VCNT(VCNT),
    .frame_start(frame_start), .bus(bus), .R(R), .G(G), .B(B)
  );

  always #5 iCLK = ~iCLK;

  // Tag follows each probed pixel through the two-cycle output latency.
  always @(posedge iCLK) begin
    p1 <= probe;
    p2 <= p1;
  end

  always @(negedge iCLK) begin
    if (p2 === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pixel_unexpected: got %06h with no expectation queued", {R, G, B});
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({R, G, B} !== e.rgb) begin
          bad++;
          $display("FAIL pixel h=%0d v=%0d: got %06h expected %06h", e.h, e.v, {R, G, B}, e.rgb);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge iCLK);
      #1;
    end
  endtask

  task automatic pix(input int h, input int v, input logic [23:0] e);
    exp_t x;
    x.rgb = e; x.h = h; x.v = v;
    HCNT  = 12'(h);
    VCNT  = 11'(v);
    probe = 1'b1;
    exp_q.push_back(x);
    step(1);
    probe = 1'b0;
  endtask

  task automatic wr(input int x, input int y, input int c);
    bus.wr_x     = 3'(x);
    bus.wr_y     = 3'(y);
    bus.wr_color = 3'(c);
    bus.wr_valid = 1'b1;
    step(1);
    bus.wr_valid = 1'b0;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
    step(2);
  endtask

  function automatic int px(input int col);
    return 512 + col * 64 + 10;
  endfunction

  function automatic int py(input int row);
    return 256 + row * 64 + 10;
  endfunction

  initial begin
    reset = 1'b1; HCNT = 12'd0; VCNT = 11'd0; frame_start = 1'b0; probe = 1'b0;
    bus.wr_valid = 1'b0; bus.wr_x = 3'd0; bus.wr_y = 3'd0; bus.wr_color = 3'd0;
    bus.flash_start = 1'b0; bus.flash_rows = 8'h00; bus.flash_cols = 8'h00;
    step(3);
    chk("reset_rgb", {8'd0, R, G, B}, 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_wr_ready", 32'(bus.wr_ready), 32'd1);
    reset = 1'b0;

    // Horizontal sweep across the board on a non-line row.
    for (int h = 0; h < 1280; h++) begin
      if (h < 512 || h >= 1024)    pix(h, 300, C_OUT);
      else if ((h - 512) % 64 == 0) pix(h, 300, C_LINE);
      else                          pix(h, 300, C_EMPTY);
    end
    step(3);

    wr(2, 1, 3);
    pix(px(2), py(1), C_YEL);
    step(3);
    wr(2, 1, 0);
    pix(px(2), py(1), C_EMPTY);
    pix(512, py(1), C_LINE);
    pix(px(2), 256, C_LINE);
    step(3);

    // Row 4 full of red, sentinel cyan at (3,0).
    wr(3, 0, 5);
    for (int c = 0; c < 8; c++) wr(c, 4, 1);
    pix(px(0), py(4), C_RED);
    step(3);

    bus.flash_rows = 8'h10; bus.flash_cols = 8'h00; bus.flash_start = 1'b1;
    step(1);
    bus.flash_start = 1'b0;
    chk("flash_busy", 32'(bus.busy), 32'd1);
    chk("flash_wr_ready", 32'(bus.wr_ready), 32'd0);
    repeat (8) frame();
    pix(px(3), py(4), C_WHITE);
    pix(px(0), py(3), C_EMPTY);
    pix(512, py(4), C_LINE);
    pix(px(3), py(0), C_CYAN);
    step(3);

    // Held write and a second start during FLASH must both be ignored.
    bus.wr_x = 3'd5; bus.wr_y = 3'd5; bus.wr_color = 3'd4; bus.wr_valid = 1'b1;
    bus.flash_rows = 8'h01; bus.flash_start = 1'b1;
    step(1);
    bus.flash_start = 1'b0;
    repeat (23) frame();
    chk("busy_frame31", 32'(bus.busy), 32'd1);
    pix(px(5), py(5), C_EMPTY);
    pix(px(7), py(4), C_WHITE);
    step(3);
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
    chk("busy_in_clear", 32'(bus.busy), 32'd1);
    chk("ready_in_clear", 32'(bus.wr_ready), 32'd0);
    step(1);
    chk("busy_after_clear", 32'(bus.busy), 32'd0);
    chk("ready_after_clear", 32'(bus.wr_ready), 32'd1);
    step(1);
    bus.wr_valid = 1'b0;
    pix(px(4), py(4), C_EMPTY);
    pix(px(0), py(4), C_EMPTY);
    pix(px(5), py(5), C_GREEN);
    pix(px(3), py(0), C_CYAN);
    step(3);

    // Write and start in the same cycle; the write lands in the cleared column.
    bus.wr_x = 3'd2; bus.wr_y = 3'd6; bus.wr_color = 3'd4; bus.wr_valid = 1'b1;
    bus.flash_rows = 8'h00; bus.flash_cols = 8'h04; bus.flash_start = 1'b1;
    step(1);
    bus.wr_valid = 1'b0; bus.flash_start = 1'b0;
    chk("same_cycle_busy", 32'(bus.busy), 32'd1);
    repeat (2) frame();
    pix(px(2), py(6), C_GREEN);
    step(3);
    repeat (30) frame();
    chk("same_cycle_done", 32'(bus.busy), 32'd0);
    pix(px(2), py(6), C_EMPTY);
    pix(px(5), py(5), C_GREEN);
    pix(px(3), py(0), C_CYAN);
    step(3);

    // Reset in the middle of FLASH.
    wr(1, 1, 6);
    bus.flash_rows = 8'h02; bus.flash_cols = 8'h00; bus.flash_start = 1'b1;
    step(1);
    bus.flash_start = 1'b0;
    repeat (10) frame();
    pix(px(1), py(1), C_WHITE);
    step(3);
    reset = 1'b1;
    step(1);
    chk("midflash_reset_busy", 32'(bus.busy), 32'd0);
    chk("midflash_reset_ready", 32'(bus.wr_ready), 32'd1);
    chk("midflash_reset_rgb", {8'd0, R, G, B}, 32'd0);
    reset = 1'b0;
    pix(px(1), py(1), C_EMPTY);
    pix(px(5), py(5), C_EMPTY);
    pix(px(3), py(0), C_EMPTY);
    step(3);
    repeat (3) frame();
    chk("post_reset_idle", 32'(bus.busy), 32'd0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/board_renderer.md
# board_renderer

Parametrised board renderer for the BlockBlast VGA pipeline, replacing the fixed 512×512 background image with a live cell grid. Given the raster position from the timing generator, it outputs RGB from an internal GRID_N×GRID_N cell-colour store. It draws grid lines and a dark surround, accepts cell writes from game logic through a valid/ready port, and runs a line-clear blink-then-erase sequence. It sits between the VGA timing counters and the RGB output mux.

## Interface
- ORG_X, 12'd512: board left edge, in pixels.
- ORG_Y, 11'd256: board top edge, in lines.
- CELL_LOG2, 6: log2 of the cell size in pixels (64 px cells).
- GRID_LOG2, 3: log2 of the cells per side; GRID_N = 1<<GRID_LOG2 (8).
- COLOR_W, 3: width of a cell colour index; index 0 means empty.
- FLASH_FRAMES, 32: number of frames the blink phase lasts, range 1..255.
- iCLK  in  1  pixel clock.
- reset  in  1  synchronous, active-high reset.
- HCNT  in  12  current horizontal pixel count.
- VCNT  in  11  current vertical line count.
- frame_start  in  1  one-cycle pulse at the start of each frame.
- wr_valid  in  1  cell write request.
- wr_ready  out  1  high when a cell write can be accepted.
- wr_x, wr_y  in  GRID_LOG2  column and row of the cell to write.
- wr_color  in  COLOR_W  colour index to write.
- flash_start  in  1  one-cycle pulse that starts a line clear.
- flash_rows, flash_cols  in  GRID_N  bit i selects row i or column i.
- busy  out  1  high while a clear sequence is running.
- R, G, B  out  8 each  pixel colour.

## Operation
- Cell store: GRID_N² entries of COLOR_W bits each. All entries are 0 after reset.
- The sequencer state machine has three states: IDLE, FLASH and CLEAR.
- wr_ready = (state==IDLE), driven combinationally from state. busy = (state!=IDLE).
- A write occurs when wr_valid && wr_ready. cell[wr_y][wr_x] <= wr_color on that clock edge.
- A write to a cell that already holds a value overwrites it; there is no error for this case.
- IDLE→FLASH: on flash_start when (flash_rows|flash_cols)!=0. On entry the masks are latched and frame_cnt is set to 0.
- flash_start with both masks zero is ignored. flash_start while busy is ignored.
- flash_start and an accepted write in the same cycle: the write commits first. FLASH starts on the next cycle.
- FLASH: frame_cnt increments on each frame_start. When frame_cnt reaches FLASH_FRAMES-1 and frame_start is asserted, the state moves to CLEAR.
- CLEAR: lasts one cycle. Every cell whose row bit or column bit is set in the latched masks is written to 0. The state then returns to IDLE.
- A marked cell is a cell whose row or column is selected in the latched masks.
- Pixel classification, using the 12-bit difference dx = HCNT−ORG_X and the 11-bit difference dy = VCNT−ORG_Y:
  - The pixel is inside the board when HCNT≥ORG_X, HCNT<ORG_X+(GRID_N<<CELL_LOG2), and the same holds for VCNT against ORG_Y.
  - The cell column is dx[CELL_LOG2+GRID_LOG2-1:CELL_LOG2]. The cell row comes from the same bit range of dy.
  - The pixel is on a grid line when either in-cell offset, dx[CELL_LOG2-1:0] or dy[CELL_LOG2-1:0], is 0.
- Colour priority, highest first:
  1. Outside the board: (38,38,38).
  2. On a grid line: (89,89,89).
  3. In FLASH, on a marked cell, with frame_cnt[3]==1: (255,255,255).
  4. Cell value 0: (64,64,64).
  5. Colour indices 1..7: red (230,60,60), orange (240,150,40), yellow (240,220,60), green (80,200,90), cyan (60,200,220), blue (60,100,230), purple (170,80,220).
  6. Any index above 7 (only possible when COLOR_W>3) uses the purple value.

## Timing
- The pixel path has a 2-stage pipeline. Stage 1 registers the inside flag, grid-line flag and cell row/column. Stage 2 reads the cell store, applies the palette and registers R/G/B.
- RGB for a given HCNT/VCNT pair appears exactly 2 cycles later.
- A cell write is visible in the pixel path no earlier than 1 cycle after the write edge. Stage 2 reads the current store contents.
- Reset values: R=G=B=0, state IDLE, wr_ready=1, busy=0, frame_cnt=0, latched masks 0, both pipeline stages cleared to the outside-board class.
- Reset asserted mid-FLASH or mid-CLEAR aborts the sequence. The store is zeroed and no partial clear remains.
- frame_cnt is 8 bits wide and saturates at FLASH_FRAMES-1. When FLASH_FRAMES=1, the state moves to CLEAR on the first frame_start after FLASH is entered.

## Test plan
- Reset, then sweep HCNT 0..1279 at VCNT=300. Expected RGB (38,38,38) for HCNT<512 and ≥1024. At HCNT=512, 576, … the output is (89,89,89), 2 cycles after the input. Elsewhere the output is (64,64,64).
- Write (x=2, y=1, color=3), then sample HCNT=512+2·64+10, VCNT=256+64+10. Expected (240,220,60). Then write color 0 to the same cell; the same pixel reads (64,64,64).
- Fill row 4 with colour 1. Pulse flash_start with rows=8'h10 and cols=0. Expected: busy=1 and wr_ready=0 the next cycle. At frame_cnt=8 the row-4 pixels read (255,255,255). After 32 frame_starts, row 4 is all 0 and busy=0.
- During FLASH, hold wr_valid=1 and pulse flash_start again. Expected: the store is unchanged and the sequence length stays 32 frames. The held write is accepted on the first IDLE cycle.
- Assert flash_start and an accepted write in the same cycle, with the write targeting a cell in the cleared column. Expected: the cell is 0 after CLEAR.
- Assert reset at frame 10 of FLASH. Expected: the next cycle shows busy=0, wr_ready=1, all cells 0 and RGB=0.
